// File: rtl/md_pkg.sv
// md_pkg: shared MDOp encoding, default latencies and FSM state type for the multiply/divide unit.
package md_pkg;
   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;
   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;
   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} md_state_t;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: E-stage issue signals into the multiply/divide unit and HI/LO/Busy back out.
interface mult_div_unit_if;
   logic        Start;
   logic [2:0]  MDOp;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        IntReq;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   modport master (output Start, MDOp, SrcA, SrcB, IntReq, input Busy, HI, LO);
   modport slave  (input Start, MDOp, SrcA, SrcB, IntReq, output Busy, HI, LO);
endinterface

// File: rtl/md_compute.sv
// md_compute: combinational 32x32 multiply and divide producing HI/LO results plus a divide-by-zero flag.
module md_compute
   import md_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_div0
);
   logic        w_sgn, w_neg_a, w_neg_b;
   logic [63:0] w_prod;
   logic [31:0] w_ma, w_mb, w_mq, w_mr;
   always_comb begin
      w_sgn   = (i_op == MD_MULT) || (i_op == MD_DIV);
      w_neg_a = w_sgn & i_a[31];
      w_neg_b = w_sgn & i_b[31];
      w_prod  = {{32{w_neg_a}}, i_a} * {{32{w_neg_b}}, i_b};
      o_div0  = (i_b == '0);
      // Divide magnitudes unsigned so 0x80000000 / -1 wraps to 0x80000000 without overflow.
      w_ma    = w_neg_a ? -i_a : i_a;
      w_mb    = o_div0 ? 32'd1 : (w_neg_b ? -i_b : i_b);
      w_mq    = w_ma / w_mb;
      w_mr    = w_ma % w_mb;
      o_hi    = (i_op == MD_DIV || i_op == MD_DIVU) ? (w_neg_a ? -w_mr : w_mr) : w_prod[63:32];
      o_lo    = (i_op == MD_DIV || i_op == MD_DIVU) ? ((w_neg_a ^ w_neg_b) ? -w_mq : w_mq) : w_prod[31:0];
   end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit; results are computed at issue, held pending,
// and committed to HI/LO after a fixed busy period.
module mult_div_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
   input logic            clk,
   input logic            reset,
   mult_div_unit_if.slave md
);
   localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
   md_state_t     r_state, w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo, w_res_hi, w_res_lo;
   logic          r_pend_div0, w_div0, w_accept, w_is_mul, w_is_div, w_long, w_commit;
   md_compute u_compute (
      .i_op  (md.MDOp),
      .i_a   (md.SrcA),
      .i_b   (md.SrcB),
      .o_hi  (w_res_hi),
      .o_lo  (w_res_lo),
      .o_div0(w_div0)
   );
   always_comb begin
      w_accept    = md.Start & ~md.IntReq & (r_state == ST_IDLE) & (md.MDOp inside {[MD_MULT:MD_MTLO]});
      w_is_mul    = (md.MDOp == MD_MULT) || (md.MDOp == MD_MULTU);
      w_is_div    = (md.MDOp == MD_DIV) || (md.MDOp == MD_DIVU);
      w_long      = w_accept & (w_is_mul | w_is_div);
      w_commit    = (r_state == ST_BUSY) && (r_cnt == '0);
      w_state_nxt = w_long ? ST_BUSY : w_commit ? ST_IDLE : r_state;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_pend_hi   <= '0;
         r_pend_lo   <= '0;
         r_pend_div0 <= 1'b0;
      end else begin
         if (w_long) begin
            r_pend_hi   <= w_res_hi;
            r_pend_lo   <= w_res_lo;
            r_pend_div0 <= w_is_div & w_div0;
            r_cnt       <= w_is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
         end else if (r_state == ST_BUSY) r_cnt <= r_cnt - 1'b1;
         if (w_commit && !r_pend_div0) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
         if (w_accept && md.MDOp == MD_MTHI) r_hi <= md.SrcA;
         if (w_accept && md.MDOp == MD_MTLO) r_lo <= md.SrcA;
      end
   end
   assign md.Busy = (r_state == ST_BUSY);
   assign md.HI   = r_hi;
   assign md.LO   = r_lo;
   // The stall unit must hold md instructions in D while busy.
   a_no_start_busy: assert property (@(posedge clk) disable iff (reset) !(md.Start && md.Busy));
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against a longint reference model.
module tb_mult_div_unit;
   import md_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   mult_div_unit_if bus();
   mult_div_unit u_dut (.clk(clk), .reset(reset), .md(bus));
   logic [2:0]  c_op;
   logic [31:0] c_a, c_b, c_hi, c_lo;
   logic        c_div0;
   md_compute u_cmp (.i_op(c_op), .i_a(c_a), .i_b(c_b), .o_hi(c_hi), .o_lo(c_lo), .o_div0(c_div0));
   int checks = 0;
   int failures = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                              input logic [63:0] prev);
      longint sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         MD_MULT:  return sa * sb;
         MD_MULTU: return 64'(a) * 64'(b);
         MD_DIV: begin
            if (b == 0) return prev;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         MD_DIVU:  return (b == 0) ? prev : {a % b, a / b};
         MD_MTHI:  return {a, prev[31:0]};
         MD_MTLO:  return {prev[63:32], a};
         default:  return prev;
      endcase
   endfunction

   function automatic int ref_busy(input logic [2:0] op);
      return (op == MD_MULT || op == MD_MULTU) ? 5 : (op == MD_DIV || op == MD_DIVU) ? 10 : 0;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int busy);
      @(negedge clk);
      bus.Start = 1'b1; bus.MDOp = op; bus.SrcA = a; bus.SrcB = b; bus.IntReq = 1'b0;
      @(negedge clk);
      bus.Start = 1'b0; bus.MDOp = MD_NONE;
      busy = 0;
      while (bus.Busy && busy < 50) begin
         busy++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      bus.Start = 1'b0; bus.MDOp = MD_NONE; bus.SrcA = '0; bus.SrcB = '0; bus.IntReq = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
      checks++; if (bus.HI !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.HI); end
      checks++; if (bus.LO !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.LO); end
      reset = 1'b0;
   endtask

   task automatic test_multiply();
      int busy;
      logic [2:0] op;
      logic [31:0] a, b;
      for (int i = 0; i < 10; i++) begin
         op = (i % 2 == 0) ? MD_MULT : MD_MULTU;
         a = (i == 0) ? 32'hFFFF_FFFE : (i == 1) ? 32'hFFFF_FFFF : $urandom;
         b = (i == 0) ? 32'd3 : (i == 1) ? 32'd2 : $urandom;
         run_op(op, a, b, busy);
         {m_hi, m_lo} = ref_result(op, a, b, {m_hi, m_lo});
         checks++; if (busy !== 5) begin failures++; $display("FAIL mul_busy[%0d] got=%0d exp=5", i, busy); end
         checks++; if ({bus.HI, bus.LO} !== {m_hi, m_lo})
            begin failures++; $display("FAIL mul_hilo[%0d] op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, bus.HI, bus.LO, m_hi, m_lo); end
      end
   endtask

   task automatic test_divide();
      int busy;
      logic [2:0] op;
      logic [31:0] a, b;
      for (int i = 0; i < 12; i++) begin
         op = (i % 2 == 0) ? MD_DIV : MD_DIVU;
         a = (i == 0) ? 32'hFFFF_FFF9 : (i == 2) ? 32'h8000_0000 : $urandom;
         b = (i == 0) ? 32'd2 : (i == 2) ? 32'hFFFF_FFFF : ($urandom_range(0, 4) == 0) ? 32'h0 :
             ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 100)) : $urandom;
         run_op(op, a, b, busy);
         {m_hi, m_lo} = ref_result(op, a, b, {m_hi, m_lo});
         checks++; if (busy !== 10) begin failures++; $display("FAIL div_busy[%0d] got=%0d exp=10", i, busy); end
         checks++; if ({bus.HI, bus.LO} !== {m_hi, m_lo})
            begin failures++; $display("FAIL div_hilo[%0d] op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, bus.HI, bus.LO, m_hi, m_lo); end
      end
   endtask

   task automatic test_div_zero();
      int busy;
      run_op(MD_MTHI, 32'h11, 32'h0, busy);
      run_op(MD_MTLO, 32'h22, 32'h0, busy);
      m_hi = 32'h11; m_lo = 32'h22;
      run_op(MD_DIVU, $urandom, 32'h0, busy);
      checks++; if (busy !== 10) begin failures++; $display("FAIL div0_busy got=%0d exp=10", busy); end
      checks++; if ({bus.HI, bus.LO} !== {32'h11, 32'h22})
         begin failures++; $display("FAIL div0_hilo got=%h_%h exp=00000011_00000022", bus.HI, bus.LO); end
   endtask

   task automatic test_move();
      int busy;
      run_op(MD_MTHI, 32'hDEAD_BEEF, $urandom, busy);
      m_hi = 32'hDEAD_BEEF;
      checks++; if (busy !== 0) begin failures++; $display("FAIL mthi_busy got=%0d exp=0", busy); end
      checks++; if (bus.HI !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mthi_hi got=%h exp=deadbeef", bus.HI); end
      checks++; if (bus.LO !== m_lo) begin failures++; $display("FAIL mthi_lo got=%h exp=%h", bus.LO, m_lo); end
      run_op(MD_MTLO, 32'h0BAD_F00D, $urandom, busy);
      checks++; if ({bus.HI, bus.LO} !== {32'hDEAD_BEEF, 32'h0BAD_F00D})
         begin failures++; $display("FAIL mtlo_hilo got=%h_%h exp=deadbeef_0badf00d", bus.HI, bus.LO); end
      m_lo = 32'h0BAD_F00D;
   endtask

   task automatic test_cancel();
      logic seen = 1'b0;
      @(negedge clk);
      bus.Start = 1'b1; bus.MDOp = MD_MULT; bus.SrcA = 32'h1234; bus.SrcB = 32'h5678; bus.IntReq = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0; bus.MDOp = MD_NONE; bus.IntReq = 1'b0;
      repeat (7) begin
         seen |= bus.Busy;
         @(negedge clk);
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", seen); end
      checks++; if ({bus.HI, bus.LO} !== {m_hi, m_lo})
         begin failures++; $display("FAIL cancel_hilo got=%h_%h exp=%h_%h", bus.HI, bus.LO, m_hi, m_lo); end
   endtask

   task automatic test_int_busy();
      int busy = 0;
      logic [31:0] a = $urandom, b = $urandom;
      @(negedge clk);
      bus.Start = 1'b1; bus.MDOp = MD_MULT; bus.SrcA = a; bus.SrcB = b;
      @(negedge clk);
      bus.Start = 1'b0; bus.MDOp = MD_NONE;
      while (bus.Busy && busy < 50) begin
         busy++;
         bus.IntReq = (busy == 3);
         @(negedge clk);
      end
      bus.IntReq = 1'b0;
      {m_hi, m_lo} = ref_result(MD_MULT, a, b, {m_hi, m_lo});
      checks++; if (busy !== 5) begin failures++; $display("FAIL intbusy_busy got=%0d exp=5", busy); end
      checks++; if ({bus.HI, bus.LO} !== {m_hi, m_lo})
         begin failures++; $display("FAIL intbusy_hilo got=%h_%h exp=%h_%h", bus.HI, bus.LO, m_hi, m_lo); end
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      @(negedge clk);
      bus.Start = 1'b1; bus.MDOp = MD_DIV; bus.SrcA = 32'd1000; bus.SrcB = 32'd7;
      @(negedge clk);
      bus.Start = 1'b0; bus.MDOp = MD_NONE;
      repeat (3) @(negedge clk);
      checks++; if (bus.Busy !== 1'b1) begin failures++; $display("FAIL rstmid_prebusy got=%b exp=1", bus.Busy); end
      reset = 1'b1;
      #1;
      m_hi = '0; m_lo = '0;
      checks++; if ({bus.Busy, bus.HI, bus.LO} !== 65'h0)
         begin failures++; $display("FAIL rstmid_async got=%b_%h_%h exp=0_0_0", bus.Busy, bus.HI, bus.LO); end
      @(negedge clk);
      reset = 1'b0;
      repeat (15) begin
         seen |= bus.Busy;
         @(negedge clk);
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", seen); end
      checks++; if ({bus.HI, bus.LO} !== 64'h0)
         begin failures++; $display("FAIL rstmid_nocommit got=%h_%h exp=0_0", bus.HI, bus.LO); end
   endtask

   task automatic test_back_to_back();
      int busy;
      logic [2:0] op;
      logic [31:0] a, b;
      for (int i = 0; i < 14; i++) begin
         op = 3'($urandom_range(1, 6));
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
         run_op(op, a, b, busy);
         {m_hi, m_lo} = ref_result(op, a, b, {m_hi, m_lo});
         checks++; if (busy !== ref_busy(op)) begin failures++; $display("FAIL b2b_busy[%0d] op=%0d got=%0d exp=%0d", i, op, busy, ref_busy(op)); end
         checks++; if ({bus.HI, bus.LO} !== {m_hi, m_lo})
            begin failures++; $display("FAIL b2b_hilo[%0d] op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, bus.HI, bus.LO, m_hi, m_lo); end
      end
   endtask

   task automatic test_compute();
      logic [63:0] exp;
      for (int i = 0; i < 24; i++) begin
         c_op = 3'($urandom_range(1, 4));
         c_a = (i == 0) ? 32'h8000_0000 : $urandom;
         c_b = (i == 0) ? 32'hFFFF_FFFF : ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
         if (i == 0) c_op = MD_DIV;
         #1;
         checks++; if (c_div0 !== (c_b == 0)) begin failures++; $display("FAIL cmp_div0[%0d] got=%b exp=%b", i, c_div0, c_b == 0); end
         if (!((c_op == MD_DIV || c_op == MD_DIVU) && c_b == 0)) begin
            exp = ref_result(c_op, c_a, c_b, 64'h0);
            checks++; if ({c_hi, c_lo} !== exp)
               begin failures++; $display("FAIL cmp_res[%0d] op=%0d a=%h b=%h got=%h_%h exp=%h", i, c_op, c_a, c_b, c_hi, c_lo, exp); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_compute();
      test_multiply();
      test_divide();
      test_div_zero();
      test_move();
      test_cancel();
      test_int_busy();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
